// File: rtl/multi_pwm_generator_pkg.sv
// Shared timing defaults for the motor PWM block (ESC-style 50 Hz frame, 1-2 ms pulses).
package multi_pwm_generator_pkg;
  localparam int PWM_PERIOD_US            = 20000;
  localparam int MIN_PWM_TIME_HIGH_US     = 1000;
  localparam int MAX_PWM_TIME_HIGH_US     = 2000;
  localparam int FAILSAFE_TIMEOUT_PERIODS = 25;
endpackage

// File: rtl/multi_pwm_generator_pwm_channel_compare.sv
// One motor channel: period-committed throttle, clamp/scale to high time, registered compare.
module pwm_channel_compare #(
  parameter int VAL_WIDTH   = 10,
  parameter int CNT_WIDTH   = 15,
  parameter int MIN_HIGH_US = 1000,
  parameter int MAX_HIGH_US = 2000
) (
  input  logic                 us_clk,
  input  logic                 reset,
  input  logic                 commit,
  input  logic [VAL_WIDTH-1:0] load_val,
  input  logic [CNT_WIDTH-1:0] cnt_next,
  input  logic                 armed_next,
  output logic                 pwm
);
  localparam int SPAN = MAX_HIGH_US - MIN_HIGH_US;
  localparam int EW   = (CNT_WIDTH > VAL_WIDTH) ? CNT_WIDTH : VAL_WIDTH;

  logic [VAL_WIDTH-1:0] active, active_next;
  logic [EW-1:0]        ext, clamped;
  logic [CNT_WIDTH-1:0] high;

  // Output is computed from next-state so it lines up with the registered counter.
  always_comb begin
    active_next = commit ? load_val : active;
    ext         = EW'(active_next);
    clamped     = (ext > EW'(SPAN)) ? EW'(SPAN) : ext;
    high        = CNT_WIDTH'(MIN_HIGH_US) + CNT_WIDTH'(clamped);
  end

  always_ff @(posedge us_clk) begin
    if (reset) begin
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      active <= active_next;
      pwm    <= armed_next && (cnt_next < high);
    end
  end
endmodule

// File: rtl/multi_pwm_generator.sv
// N-channel ESC PWM: free-running period counter, double-buffered throttle, arming and link-loss failsafe.
module multi_pwm_generator
  import multi_pwm_generator_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int VAL_WIDTH       = 10,
  parameter int PERIOD_US       = PWM_PERIOD_US,
  parameter int MIN_HIGH_US     = MIN_PWM_TIME_HIGH_US,
  parameter int MAX_HIGH_US     = MAX_PWM_TIME_HIGH_US,
  parameter int TIMEOUT_PERIODS = FAILSAFE_TIMEOUT_PERIODS
) (
  input  logic                              us_clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_CHANNELS*VAL_WIDTH-1:0] motor_vals,
  input  logic                              update_valid,
  output logic [NUM_CHANNELS-1:0]           motor_pwm,
  output logic                              period_start,
  output logic                              armed,
  output logic                              failsafe
);
  localparam int CW = $clog2(PERIOD_US);
  localparam int TW = $clog2(TIMEOUT_PERIODS + 2);

  logic [NUM_CHANNELS-1:0][VAL_WIDTH-1:0] vals_in, shadow, load_vals;
  logic [CW-1:0] cnt, cnt_next;
  logic [TW-1:0] to_cnt, to_next;
  logic          run, boundary, upd_seen, fs_next, armed_next;

  assign vals_in = motor_vals;

  always_comb begin
    boundary = run && (cnt == CW'(PERIOD_US - 1));
    cnt_next = (!run || boundary) ? '0 : cnt + 1'b1;
    // A period counts as silent only if no strobe arrived anywhere in it, boundary cycle included.
    if (upd_seen || update_valid)            to_next = '0;
    else if (to_cnt >= TW'(TIMEOUT_PERIODS)) to_next = to_cnt;
    else                                     to_next = to_cnt + 1'b1;
    fs_next    = (TIMEOUT_PERIODS != 0) && (to_next >= TW'(TIMEOUT_PERIODS));
    armed_next = boundary ? enable : armed;
    load_vals  = '0;
    if (!fs_next) load_vals = update_valid ? vals_in : shadow;
  end

  always_ff @(posedge us_clk) begin
    if (reset) begin
      cnt          <= '0;
      run          <= 1'b0;
      shadow       <= '0;
      armed        <= 1'b0;
      failsafe     <= 1'b0;
      period_start <= 1'b0;
      to_cnt       <= '0;
      upd_seen     <= 1'b0;
    end else begin
      run          <= 1'b1;
      cnt          <= cnt_next;
      period_start <= !run || boundary;
      if (update_valid) shadow <= vals_in;
      if (boundary) begin
        armed    <= enable;
        failsafe <= fs_next;
        to_cnt   <= to_next;
        upd_seen <= 1'b0;
      end else if (update_valid) begin
        upd_seen <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    pwm_channel_compare #(
      .VAL_WIDTH  (VAL_WIDTH),
      .CNT_WIDTH  (CW),
      .MIN_HIGH_US(MIN_HIGH_US),
      .MAX_HIGH_US(MAX_HIGH_US)
    ) u_ch (
      .us_clk    (us_clk),
      .reset     (reset),
      .commit    (boundary),
      .load_val  (load_vals[i]),
      .cnt_next  (cnt_next),
      .armed_next(armed_next),
      .pwm       (motor_pwm[i])
    );
  end
endmodule
